// File: rtl/relay_seq_pkg.sv
// Shared types and helpers for the CH1/CH2 input-range relay sequencer.
// The optional switch counters are enabled with the RELAY_SEQ_CNT_EN macro in the top.
package relay_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRE    = 2'd1,
        SETTLE = 2'd2
    } seq_state_t;

    typedef struct packed {
        seq_state_t state;
        logic [1:0] stab_valid;   // {ch2, ch1} stabilizer counters saturated
    } relay_dbg_t;

    localparam logic [1:0] RLY_11 = 2'b11;
    localparam logic [1:0] RLY_01 = 2'b01;
    localparam logic [1:0] RLY_10 = 2'b10;
    localparam logic [1:0] RLY_00 = 2'b00;

    function automatic logic [1:0] range_to_relay(input logic [3:0] code);
        logic [1:0] r;
        if (code <= 4'd3)      r = RLY_11;
        else if (code <= 4'd5) r = RLY_01;
        else if (code <= 4'd8) r = RLY_10;
        else                   r = RLY_00;
        return r;
    endfunction

endpackage

// File: rtl/range_code_stabilizer.sv
// Debounces one encoder gain code: a code is accepted once it has been seen unchanged
// for STABLE_CYC clocks; the last accepted code is held while the input is moving.
module range_code_stabilizer #(
    parameter logic [15:0] STABLE_CYC = 16'd50000
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [3:0] num,
    output logic [3:0] accepted,
    output logic       valid
);

    localparam int CW = $clog2(int'(STABLE_CYC) + 1);
    localparam logic [CW-1:0] STABLE_LIM = CW'(int'(STABLE_CYC));

    logic [3:0]    sample_q;
    logic [3:0]    acc_q;
    logic [CW-1:0] cnt_q;

    assign valid    = (cnt_q == STABLE_LIM);
    assign accepted = valid ? sample_q : acc_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sample_q <= 4'd0;
            acc_q    <= 4'd0;
            cnt_q    <= '0;
        end else begin
            sample_q <= num;
            if (num != sample_q)
                cnt_q <= '0;
            else if (cnt_q != STABLE_LIM)
                cnt_q <= cnt_q + 1'b1;
            acc_q <= accepted;
        end
    end

endmodule

// File: rtl/relay_range_sequencer.sv
// Range-relay sequencer: one relay change at a time, ADC blanked before and after each switch.
// Define RELAY_SEQ_CNT_EN to add the per-channel completed-switch counters.
module relay_range_sequencer
    import relay_seq_pkg::*;
#(
    parameter logic [15:0] STABLE_CYC = 16'd50000,
    parameter logic [7:0]  PRE_CYC    = 8'd16,
    parameter logic [23:0] SETTLE_CYC = 24'd500000
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [3:0]  ch1_num,
    input  logic [3:0]  ch2_num,
    output logic [1:0]  relay_ad1,
    output logic [1:0]  relay_ad2,
    output logic        adc1_ok,
    output logic        adc2_ok,
    output logic        busy,
    output logic        active_ch,
`ifdef RELAY_SEQ_CNT_EN
    output logic [15:0] ch1_sw_cnt,
    output logic [15:0] ch2_sw_cnt,
`endif
    output relay_dbg_t  dbg
);

    localparam int PW = $clog2(int'(PRE_CYC) + 1);
    localparam int SW = $clog2(int'(SETTLE_CYC) + 1);
    localparam int TW = (PW > SW) ? PW : SW;
    localparam logic [TW-1:0] PRE_LAST    = TW'(int'(PRE_CYC) - 1);
    localparam logic [TW-1:0] SETTLE_LAST = TW'(int'(SETTLE_CYC) - 1);

    logic [3:0] acc1, acc2;
    logic       valid1, valid2;

    range_code_stabilizer #(.STABLE_CYC(STABLE_CYC)) u_stab_ch1 (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .num      (ch1_num),
        .accepted (acc1),
        .valid    (valid1)
    );

    range_code_stabilizer #(.STABLE_CYC(STABLE_CYC)) u_stab_ch2 (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .num      (ch2_num),
        .accepted (acc2),
        .valid    (valid2)
    );

    seq_state_t    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [1:0]    relay1_q, relay1_d, relay2_q, relay2_d;
    logic [1:0]    target_q, target_d;
    logic          adc1_q, adc1_d, adc2_q, adc2_d;
    logic          grant_q, grant_d;
    logic          rr_q, rr_d;     // last channel served (1 = CH2)

    logic [1:0] map1, map2;
    logic       pend1, pend2, arb_pick, seq_done;

    assign map1  = range_to_relay(acc1);
    assign map2  = range_to_relay(acc2);
    assign pend1 = (map1 != relay1_q);
    assign pend2 = (map2 != relay2_q);
    // On a tie the channel not served last wins; otherwise the only pending one.
    assign arb_pick = (pend1 && pend2) ? ~rr_q : pend2;
    assign seq_done = (state_q == SETTLE) && (timer_q == SETTLE_LAST);

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        relay1_d = relay1_q;
        relay2_d = relay2_q;
        target_d = target_q;
        adc1_d   = adc1_q;
        adc2_d   = adc2_q;
        grant_d  = grant_q;
        rr_d     = rr_q;
        case (state_q)
            IDLE: begin
                if (pend1 || pend2) begin
                    grant_d  = arb_pick;
                    target_d = arb_pick ? map2 : map1;
                    state_d  = PRE;
                    timer_d  = '0;
                    if (arb_pick) adc2_d = 1'b0;
                    else          adc1_d = 1'b0;
                end
            end
            PRE: begin
                if (timer_q == PRE_LAST) begin
                    state_d = SETTLE;
                    timer_d = '0;
                    if (grant_q) relay2_d = target_q;
                    else         relay1_d = target_q;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            SETTLE: begin
                if (seq_done) begin
                    state_d = IDLE;
                    timer_d = '0;
                    rr_d    = grant_q;
                    if (grant_q) adc2_d = 1'b1;
                    else         adc1_d = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            relay1_q <= RLY_11;
            relay2_q <= RLY_11;
            target_q <= RLY_11;
            adc1_q   <= 1'b1;
            adc2_q   <= 1'b1;
            grant_q  <= 1'b0;
            rr_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            relay1_q <= relay1_d;
            relay2_q <= relay2_d;
            target_q <= target_d;
            adc1_q   <= adc1_d;
            adc2_q   <= adc2_d;
            grant_q  <= grant_d;
            rr_q     <= rr_d;
        end
    end

`ifdef RELAY_SEQ_CNT_EN
    logic [15:0] cnt1_q, cnt2_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt1_q <= 16'd0;
            cnt2_q <= 16'd0;
        end else if (seq_done) begin
            if (grant_q) cnt2_q <= cnt2_q + 16'd1;
            else         cnt1_q <= cnt1_q + 16'd1;
        end
    end

    assign ch1_sw_cnt = cnt1_q;
    assign ch2_sw_cnt = cnt2_q;
`endif

    assign relay_ad1      = relay1_q;
    assign relay_ad2      = relay2_q;
    assign adc1_ok        = adc1_q;
    assign adc2_ok        = adc2_q;
    assign busy           = (state_q != IDLE);
    assign active_ch      = grant_q;
    assign dbg.state      = state_q;
    assign dbg.stab_valid = {valid2, valid1};

endmodule

// File: tb/tb_relay_range_sequencer.sv
// Bench for relay_range_sequencer: directed scenarios plus random code changes against an
// edge-indexed reference model. Counter ports are checked when RELAY_SEQ_CNT_EN is defined.
module tb_relay_range_sequencer;
    import relay_seq_pkg::*;

    localparam int STABLE = 4;
    localparam int PRE_N  = 2;
    localparam int SET_N  = 8;

    logic        sys_clk;
    logic        sys_rst;
    logic [3:0]  ch1_num, ch2_num;
    logic [1:0]  relay_ad1, relay_ad2;
    logic        adc1_ok, adc2_ok, busy, active_ch;
    relay_dbg_t  dbg;
`ifdef RELAY_SEQ_CNT_EN
    logic [15:0] ch1_sw_cnt, ch2_sw_cnt;
`endif

    relay_range_sequencer #(
        .STABLE_CYC (16'(STABLE)),
        .PRE_CYC    (8'(PRE_N)),
        .SETTLE_CYC (24'(SET_N))
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .ch1_num    (ch1_num),
        .ch2_num    (ch2_num),
        .relay_ad1  (relay_ad1),
        .relay_ad2  (relay_ad2),
        .adc1_ok    (adc1_ok),
        .adc2_ok    (adc2_ok),
        .busy       (busy),
        .active_ch  (active_ch),
`ifdef RELAY_SEQ_CNT_EN
        .ch1_sw_cnt (ch1_sw_cnt),
        .ch2_sw_cnt (ch2_sw_cnt),
`endif
        .dbg        (dbg)
    );

    // clock / reset
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int vectors = 0;
    int miscompares = 0;

    // reference model: a sequence granted at edge s blanks edges s..s+PRE+SETTLE-1,
    // moves the relay at edge s+PRE and completes at edge s+PRE+SETTLE
    int         edge_n = 0;
    logic [1:0] m_relay [2];
    logic [3:0] m_acc [2];
    logic [3:0] m_last [2];
    int         m_run [2];
    bit         seq_on;
    int         s_edge;
    int         g;
    logic [1:0] tgt;
    int         last_served;
    logic       m_active;
    logic [15:0] m_cnt [2];
    logic [3:0] nums [2];
    bit         p1, p2;

    function automatic logic [1:0] ref_map(input logic [3:0] c);
        case (c) inside
            [4'd0:4'd3]: return 2'b11;
            [4'd4:4'd5]: return 2'b01;
            [4'd6:4'd8]: return 2'b10;
            default:     return 2'b00;
        endcase
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_relay[c] = 2'b11;
            m_acc[c]   = 4'd0;
            m_last[c]  = 4'd0;
            m_run[c]   = 1;
            m_cnt[c]   = 16'd0;
        end
        seq_on      = 1'b0;
        s_edge      = 0;
        g           = 0;
        tgt         = 2'b11;
        last_served = 1;
        m_active    = 1'b0;
    endtask

    initial model_reset();

    always @(posedge sys_clk) begin
        edge_n++;
        nums[0] = ch1_num;
        nums[1] = ch2_num;
        if (sys_rst) begin
            model_reset();
        end else begin
            if (!seq_on) begin
                p1 = (ref_map(m_acc[0]) != m_relay[0]);
                p2 = (ref_map(m_acc[1]) != m_relay[1]);
                if (p1 || p2) begin
                    g        = (p1 && p2) ? (last_served == 1 ? 0 : 1) : (p1 ? 0 : 1);
                    tgt      = ref_map(m_acc[g]);
                    s_edge   = edge_n;
                    seq_on   = 1'b1;
                    m_active = (g == 1);
                end
            end
            if (seq_on && edge_n == s_edge + PRE_N)
                m_relay[g] = tgt;
            if (seq_on && edge_n == s_edge + PRE_N + SET_N) begin
                seq_on      = 1'b0;
                last_served = g;
                m_cnt[g]    = m_cnt[g] + 16'd1;
            end
            for (int c = 0; c < 2; c++) begin
                if (nums[c] == m_last[c]) begin
                    if (m_run[c] < STABLE + 1) m_run[c]++;
                end else begin
                    m_last[c] = nums[c];
                    m_run[c]  = 1;
                end
                if (m_run[c] == STABLE + 1) m_acc[c] = m_last[c];
            end
        end
    end

    // scoreboard
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    task automatic check_all();
        chk("relay_ad1", 16'(relay_ad1), 16'(m_relay[0]));
        chk("relay_ad2", 16'(relay_ad2), 16'(m_relay[1]));
        chk("adc1_ok", 16'(adc1_ok), 16'(!(seq_on && g == 0)));
        chk("adc2_ok", 16'(adc2_ok), 16'(!(seq_on && g == 1)));
        chk("busy", 16'(busy), 16'(seq_on));
        chk("active_ch", 16'(active_ch), 16'(m_active));
        chk("dbg_state_busy", 16'(dbg.state != IDLE), 16'(seq_on));
        chk("stab_valid", 16'(dbg.stab_valid), 16'({m_run[1] == STABLE + 1, m_run[0] == STABLE + 1}));
        chk("adc_no_overlap", 16'(adc1_ok | adc2_ok), 16'd1);
`ifdef RELAY_SEQ_CNT_EN
        chk("ch1_sw_cnt", ch1_sw_cnt, m_cnt[0]);
        chk("ch2_sw_cnt", ch2_sw_cnt, m_cnt[1]);
`endif
    endtask

    // driver
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge sys_clk);
            @(negedge sys_clk);
            check_all();
        end
    endtask

    task automatic pulse_reset();
        sys_rst = 1'b1;
        step(1);
        sys_rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    int r;

    initial begin
        sys_rst = 1'b1;
        ch1_num = 4'd0;
        ch2_num = 4'd0;
        step(3);
        sys_rst = 1'b0;

        // idle with codes 0: nothing happens
        step(30);
        chk("t1_relay1", 16'(relay_ad1), 16'(RLY_11));
        chk("t1_busy", 16'(busy), 16'd0);

        // single CH1 switch to code 7
        ch1_num = 4'd7;
        step(5);
        chk("t2_not_yet", 16'(busy), 16'd0);
        step(1);
        chk("t2_granted", 16'(busy), 16'd1);
        chk("t2_adc1_low", 16'(adc1_ok), 16'd0);
        step(1);
        chk("t2_relay_pre", 16'(relay_ad1), 16'(RLY_11));
        step(1);
        chk("t2_relay_set", 16'(relay_ad1), 16'(RLY_10));
        step(13);
        chk("t2_relay_final", 16'(relay_ad1), 16'(RLY_10));
        chk("t2_adc1_back", 16'(adc1_ok), 16'd1);

        // simultaneous change after fresh reset: CH1 first
        ch1_num = 4'd0;
        pulse_reset();
        ch1_num = 4'd10;
        ch2_num = 4'd4;
        step(16);
        chk("t3_relay1_first", 16'(relay_ad1), 16'(RLY_00));
        chk("t3_relay2_waits", 16'(relay_ad2), 16'(RLY_11));
        step(20);
        chk("t3_relay2_done", 16'(relay_ad2), 16'(RLY_01));

        // glitch shorter than the stability window
        ch1_num = 4'd0;
        ch2_num = 4'd0;
        pulse_reset();
        ch1_num = 4'd5;
        step(3);
        ch1_num = 4'd0;
        step(20);
        chk("t4_relay1", 16'(relay_ad1), 16'(RLY_11));

        // code changes during SETTLE: second sequence follows
        ch1_num = 4'd5;
        step(8);
        ch1_num = 4'd12;
        step(30);
        chk("t5_relay1", 16'(relay_ad1), 16'(RLY_00));
`ifdef RELAY_SEQ_CNT_EN
        chk("t5_cnt1", ch1_sw_cnt, 16'd2);
`endif
        ch1_num = 4'd0;
        pulse_reset();
        ch1_num = 4'd2;
        step(20);
        chk("t5_same_map", 16'(relay_ad1), 16'(RLY_11));

        // reset in the middle of a CH2 SETTLE
        ch2_num = 4'd9;
        step(9);
        chk("t6_in_seq", 16'(busy), 16'd1);
        pulse_reset();
        chk("t6_relay2", 16'(relay_ad2), 16'(RLY_11));
        chk("t6_adc2", 16'(adc2_ok), 16'd1);
        chk("t6_busy", 16'(busy), 16'd0);
        ch2_num = 4'd0;
        step(20);

        // random code traffic
        for (int it = 0; it < 250; it++) begin
            r = int'($urandom_range(0, 39));
            if (r == 0) begin
                pulse_reset();
            end else if (r < 20) begin
                ch1_num = 4'($urandom_range(0, 15));
            end else if (r < 36) begin
                ch2_num = 4'($urandom_range(0, 15));
            end else begin
                ch1_num = 4'($urandom_range(0, 15));
                ch2_num = 4'($urandom_range(0, 15));
            end
            step(int'($urandom_range(1, 25)));
        end
        step(40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
